// File: rtl/systolic_pkg.sv
// ============================================================================
// Module  : systolic_pkg
// Purpose : Shared types and Q1.15 constants for the systolic PE sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_LOAD  = 3'd3,
        S_MAC   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } seq_state_t;

    localparam logic [15:0] Q15_ONE_HALF = 16'h4000;
    localparam logic [15:0] Q15_MAX      = 16'h7FFF;
    localparam logic [15:0] Q15_MIN      = 16'h8000;

endpackage

`default_nettype wire

// File: rtl/systolic_pe_sequencer_if.sv
// ============================================================================
// Module  : systolic_pe_sequencer_if
// Purpose : Job, operand, PE-control and result signals of the sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface systolic_pe_sequencer_if #(
    parameter int DATA_BITS = 16,
    parameter int LEN_BITS  = 5
);
    logic                 job_valid;
    logic                 job_ready;
    logic [LEN_BITS-1:0]  job_len;
    logic                 op_valid;
    logic                 op_ready;
    logic [DATA_BITS-1:0] op_a;
    logic [DATA_BITS-1:0] op_b;
    logic                 pe_enable;
    logic                 pe_clear_acc;
    logic                 pe_load_weight;
    logic                 pe_compute_enable;
    logic [DATA_BITS-1:0] pe_a_in;
    logic [DATA_BITS-1:0] pe_b_in;
    logic [DATA_BITS-1:0] pe_acc_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [DATA_BITS-1:0] res_data;

    // Sequencer side: initiator towards the PE, responder towards the scheduler
    modport master (
        input  job_valid, job_len, op_valid, op_a, op_b, pe_acc_out, res_ready,
        output job_ready, op_ready, pe_enable, pe_clear_acc, pe_load_weight,
               pe_compute_enable, pe_a_in, pe_b_in, res_valid, res_data
    );

    modport slave (
        output job_valid, job_len, op_valid, op_a, op_b, pe_acc_out, res_ready,
        input  job_ready, op_ready, pe_enable, pe_clear_acc, pe_load_weight,
               pe_compute_enable, pe_a_in, pe_b_in, res_valid, res_data
    );

endinterface

`default_nettype wire

// File: rtl/systolic_pe_sequencer.sv
// ============================================================================
// Module  : systolic_pe_sequencer
// Purpose : Drives one systolic PE through a dot-product job and returns acc_out.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_pe_sequencer
    import systolic_pkg::*;
#(
    parameter int DATA_BITS  = 16,
    parameter int MAX_LEN    = 16,
    parameter int LEN_BITS   = $clog2(MAX_LEN + 1),
    parameter int PE_LATENCY = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic enable,
    output logic      busy,
    systolic_pe_sequencer_if.master bus
);

    localparam int c_DCNT_BITS = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    logic [LEN_BITS-1:0]    r_len;
    logic [LEN_BITS-1:0]    r_cnt;
    logic [LEN_BITS-1:0]    w_cnt_inc;
    logic [LEN_BITS-1:0]    w_len_clamped;
    logic [c_DCNT_BITS-1:0] r_dcnt;
    logic [DATA_BITS-1:0]   r_a;
    logic [DATA_BITS-1:0]   r_pe_a;
    logic [DATA_BITS-1:0]   r_pe_b;
    logic [DATA_BITS-1:0]   r_res;
    logic                   w_job_fire;
    logic                   w_op_fire;
    logic                   w_drain_last;

    assign w_job_fire    = bus.job_valid && bus.job_ready;
    assign w_op_fire     = bus.op_valid && bus.op_ready;
    assign w_cnt_inc     = r_cnt + LEN_BITS'(1);
    assign w_drain_last  = (r_dcnt == c_DCNT_BITS'(PE_LATENCY - 1));
    assign w_len_clamped = (bus.job_len > LEN_BITS'(MAX_LEN)) ? LEN_BITS'(MAX_LEN) : bus.job_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (enable) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_job_fire) w_next_state = S_CLEAR;
            S_CLEAR: w_next_state = (r_len == '0) ? S_DRAIN : S_FETCH;
            S_FETCH: if (w_op_fire) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_MAC;
            S_MAC:   w_next_state = (w_cnt_inc == r_len) ? S_DRAIN : S_FETCH;
            S_DRAIN: if (w_drain_last) w_next_state = S_DONE;
            S_DONE:  if (bus.res_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // The weight goes straight to its output register at fetch; the activation
    // is staged so it reaches the PE one cycle later, aligned with the MAC pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_dcnt <= '0;
            r_a    <= '0;
            r_pe_a <= '0;
            r_pe_b <= '0;
            r_res  <= '0;
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (w_job_fire) begin
                        r_len <= w_len_clamped;
                        r_cnt <= '0;
                    end
                end
                S_CLEAR: r_dcnt <= '0;
                S_FETCH: begin
                    if (w_op_fire) begin
                        r_a    <= bus.op_a;
                        r_pe_b <= bus.op_b;
                    end
                end
                S_LOAD:  r_pe_a <= r_a;
                S_MAC:   r_cnt  <= w_cnt_inc;
                S_DRAIN: begin
                    r_dcnt <= w_drain_last ? '0 : r_dcnt + c_DCNT_BITS'(1);
                    if (w_drain_last) r_res <= bus.pe_acc_out;
                end
                default: ;
            endcase
        end
    end

    // job_ready is also masked by reset so every output except pe_enable reads 0 in reset.
    always_comb begin
        bus.job_ready         = 1'b0;
        bus.op_ready          = 1'b0;
        bus.pe_clear_acc      = 1'b0;
        bus.pe_load_weight    = 1'b0;
        bus.pe_compute_enable = 1'b0;
        bus.res_valid         = 1'b0;
        case (r_state)
            S_IDLE:  bus.job_ready         = enable & rst_n;
            S_CLEAR: bus.pe_clear_acc      = 1'b1;
            S_FETCH: bus.op_ready          = enable;
            S_LOAD:  bus.pe_load_weight    = 1'b1;
            S_MAC:   bus.pe_compute_enable = 1'b1;
            S_DONE:  bus.res_valid         = 1'b1;
            default: ;
        endcase
    end

    assign bus.pe_enable = enable;
    assign bus.pe_a_in   = r_pe_a;
    assign bus.pe_b_in   = r_pe_b;
    assign bus.res_data  = r_res;
    assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_systolic_pe_sequencer.sv
// ============================================================================
// Module  : tb_systolic_pe_sequencer
// Purpose : Scoreboard bench pairing the sequencer with a behavioural Q1.15 PE.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_systolic_pe_sequencer;
    import systolic_pkg::*;

    localparam int DATA_BITS  = 16;
    localparam int MAX_LEN    = 16;
    localparam int LEN_BITS   = 5;
    localparam int PE_LATENCY = 1;

    typedef struct { logic [15:0] a; logic [15:0] b; int gap; } pair_t;
    typedef struct { logic [15:0] data; int n; int lat; } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable;
    logic        busy;
    logic [15:0] pe_acc;
    logic [15:0] pe_w;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    pair_t op_q[$];
    exp_t  sb[$];
    bit    rand_mode        = 1'b0;
    bit    load_stall_armed = 1'b0;
    int    en_stall         = 0;

    systolic_pe_sequencer_if #(.DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)) bus ();

    systolic_pe_sequencer #(
        .DATA_BITS (DATA_BITS),
        .MAX_LEN   (MAX_LEN),
        .LEN_BITS  (LEN_BITS),
        .PE_LATENCY(PE_LATENCY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Q1.15 multiply with round-half-up, accumulate, saturate.
    function automatic logic [15:0] q15_mac(input logic [15:0] acc, input logic [15:0] a,
                                            input logic [15:0] b);
        longint p, s;
        p = longint'($signed(a)) * longint'($signed(b));
        s = longint'($signed(acc)) + ((p + 64'sd16384) >>> 15);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic logic [15:0] ref_dot(input pair_t q[$], input int n);
        logic [15:0] acc = 16'h0000;
        for (int i = 0; i < n; i++) acc = q15_mac(acc, q[i].a, q[i].b);
        return acc;
    endfunction

    // Behavioural PE sharing the sequencer's reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_acc <= '0;
            pe_w   <= '0;
        end else if (bus.pe_enable) begin
            if (bus.pe_clear_acc) pe_acc <= '0;
            else if (bus.pe_compute_enable) pe_acc <= q15_mac(pe_acc, bus.pe_a_in, pe_w);
            if (bus.pe_load_weight) pe_w <= bus.pe_b_in;
        end
    end
    assign bus.pe_acc_out = pe_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_job_ready", 32'(bus.job_ready), 0);
        check("rst_op_ready", 32'(bus.op_ready), 0);
        check("rst_clear_acc", 32'(bus.pe_clear_acc), 0);
        check("rst_load_weight", 32'(bus.pe_load_weight), 0);
        check("rst_compute_en", 32'(bus.pe_compute_enable), 0);
        check("rst_pe_a_in", 32'(bus.pe_a_in), 0);
        check("rst_pe_b_in", 32'(bus.pe_b_in), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pe_enable", 32'(bus.pe_enable), 32'(enable));
    endtask

    // Operand feeder: a pair's gap counts cycles the sequencer is asking for it
    initial begin
        bit    fire;
        pair_t p;
        bus.op_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        forever begin
            @(negedge clk);
            fire = bus.op_valid && bus.op_ready;
            if (op_q.size() > 0 && op_q[0].gap > 0 && bus.op_ready) begin
                p = op_q[0];
                p.gap--;
                op_q[0] = p;
            end
            @(posedge clk);
            #1;
            if (fire && op_q.size() > 0) void'(op_q.pop_front());
            if (op_q.size() > 0 && op_q[0].gap == 0 && !(rand_mode && $urandom_range(0, 3) == 0)) begin
                bus.op_valid = 1'b1;
                bus.op_a     = op_q[0].a;
                bus.op_b     = op_q[0].b;
            end else begin
                bus.op_valid = 1'b0;
                bus.op_a     = 16'($urandom);
                bus.op_b     = 16'($urandom);
            end
        end
    end

    // enable and res_ready share one driver so a result is never offered while frozen
    initial begin
        enable        = 1'b1;
        bus.res_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (load_stall_armed && bus.op_valid && bus.op_ready) begin
                en_stall         = 3;
                load_stall_armed = 1'b0;
            end
            @(posedge clk);
            #1;
            if (en_stall > 0) begin
                enable = 1'b0;
                en_stall--;
            end else begin
                enable = !(rand_mode && $urandom_range(0, 9) == 0);
            end
            bus.res_ready = enable && !(rand_mode && $urandom_range(0, 2) == 0);
        end
    end

    // Monitor: per-job pulse accounting and scoreboard comparison
    initial begin
        int          hs_cyc = 0, first_cyc = 0;
        int          clr_cnt = 0, ld_cnt = 0, cmp_cnt = 0, op_cnt = 0;
        bit          prev_rv = 1'b0, hold_rv = 1'b0;
        logic [15:0] hold_data = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rv = 1'b0;
                hold_rv = 1'b0;
                clr_cnt = 0; ld_cnt = 0; cmp_cnt = 0; op_cnt = 0;
            end else begin
                if (!enable) check("freeze_ready", {30'd0, bus.job_ready, bus.op_ready}, 0);
                if (bus.job_valid && bus.job_ready) begin
                    hs_cyc  = cyc;
                    clr_cnt = 0; ld_cnt = 0; cmp_cnt = 0; op_cnt = 0;
                end
                if (bus.pe_enable && bus.pe_clear_acc) clr_cnt++;
                if (bus.pe_enable && bus.pe_load_weight) ld_cnt++;
                if (bus.pe_enable && bus.pe_compute_enable) cmp_cnt++;
                if (bus.op_valid && bus.op_ready) op_cnt++;
                if (bus.res_valid && !prev_rv) first_cyc = cyc;
                if (bus.res_valid) check("busy_in_done", 32'(busy), 1);
                if (bus.res_valid && hold_rv) check("res_hold", 32'(bus.res_data), 32'(hold_data));
                if (bus.res_valid && bus.res_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'(sb.size()), 1);
                    end else begin
                        e = sb.pop_front();
                        check("res_data", 32'(bus.res_data), 32'(e.data));
                        check("clear_pulses", 32'(clr_cnt), 1);
                        check("load_pulses", 32'(ld_cnt), 32'(e.n));
                        check("compute_pulses", 32'(cmp_cnt), 32'(e.n));
                        check("ops_consumed", 32'(op_cnt), 32'(e.n));
                        if (e.lat >= 0) check("res_latency", 32'(first_cyc - hs_cyc), 32'(e.lat));
                    end
                end
                prev_rv   = bus.res_valid;
                hold_rv   = bus.res_valid && !bus.res_ready;
                hold_data = bus.res_data;
            end
        end
    end

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
        pair_t p;
        p.a = a; p.b = b; p.gap = gap;
        op_q.push_back(p);
    endtask

    task automatic run_job(input int len, input logic [15:0] exp_data, input int exp_lat);
        exp_t e;
        int   t;
        e.data = exp_data;
        e.n    = (len > MAX_LEN) ? MAX_LEN : len;
        e.lat  = exp_lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_len   = LEN_BITS'(len);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.job_ready && t < 200);
        check("job_accept", 32'(bus.job_ready), 1);
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        bus.job_len   = LEN_BITS'($urandom);
        t = 0;
        while (sb.size() > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("result_returned", 32'(sb.size()), 0);
        sb.delete();
        @(posedge clk);
        #1;
        op_q.delete();
    endtask

    initial begin
        int          len, t;
        logic [15:0] exp_d;
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        rst_n = 1'b1;

        push_pair(Q15_ONE_HALF, Q15_ONE_HALF, 0);
        run_job(1, 16'h2000, 6);

        push_pair(16'h4000, 16'h4000, 0);
        push_pair(16'h2000, 16'h4000, 0);
        run_job(2, 16'h3000, 9);
        push_pair(16'hC000, 16'h4000, 0);
        run_job(1, 16'hE000, 6);

        repeat (4) push_pair(Q15_MAX, Q15_MAX, 0);
        run_job(4, 16'h7FFF, 15);

        run_job(0, 16'h0000, 3);

        // Operand gap of 5 fetch cycles plus a 3-cycle freeze on the first LOAD
        load_stall_armed = 1'b1;
        push_pair(16'h4000, 16'h4000, 0);
        push_pair(16'h2000, 16'h4000, 5);
        run_job(2, 16'h3000, 17);

        // Asynchronous reset while a MAC pulse is on the bus
        repeat (4) push_pair(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)), 0);
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_len   = LEN_BITS'(4);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.job_ready && t < 200);
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.pe_compute_enable && t < 200);
        check("mac_reached", 32'(bus.pe_compute_enable), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        op_q.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Over-length job is clamped; the four surplus pairs stay unconsumed
        repeat (20) push_pair(16'($urandom), 16'($urandom), 0);
        exp_d = ref_dot(op_q, MAX_LEN);
        run_job(20, exp_d, 2 + 3 * MAX_LEN + PE_LATENCY);

        rand_mode = 1'b1;
        repeat (14) begin
            len = $urandom_range(0, MAX_LEN + 3);
            for (int i = 0; i < len; i++) push_pair(16'($urandom), 16'($urandom), 0);
            exp_d = ref_dot(op_q, (len > MAX_LEN) ? MAX_LEN : len);
            run_job(len, exp_d, -1);
        end
        rand_mode = 1'b0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

endmodule

`default_nettype wire
